// File: rtl/seq_detect_prog.sv
// Run-time programmable serial pattern detector (Moore) with overlapping or
// non-overlapping matching and a saturating match counter.
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 'h0B,
  parameter int                 RST_LEN     = 4,
  parameter bit                 RST_OVERLAP = 1'b1,
  localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               en,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   cur_len
);

  localparam int IW = $clog2(MAX_LEN);

  typedef enum logic {
    RUN_NORMAL,
    RUN_RESTART
  } mode_t;

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [LEN_W-1:0]   state;
  logic [CNT_W-1:0]   cnt;
  logic               z_q;
  logic [MAX_LEN-2:0] hist;

  logic [MAX_LEN-1:0] h;
  logic [LEN_W-1:0]   next_state;
  logic [LEN_W-1:0]   len_clamped;
  logic               prefix_ok;
  int                 idx;
  mode_t              mode;

  assign h = {hist, x};

  // Out-of-range lengths are folded into 1..MAX_LEN so the match state is always reachable.
  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0)
      len_clamped = LEN_W'(1);
    else if (cfg_len > LEN_W'(MAX_LEN))
      len_clamped = LEN_W'(MAX_LEN);
  end

  // Non-overlap after a full match restarts from scratch; otherwise take the
  // longest pattern prefix that is a suffix of the recent history (KMP-style).
  always_comb begin
    mode       = (state == len_q && !ovl_q) ? RUN_RESTART : RUN_NORMAL;
    next_state = '0;
    prefix_ok  = 1'b0;
    idx        = 0;
    if (mode == RUN_RESTART) begin
      next_state = (x == pat_q[IW'(len_q - LEN_W'(1))]) ? LEN_W'(1) : '0;
    end else begin
      for (int k = 1; k <= MAX_LEN; k++) begin
        prefix_ok = (k <= int'(state) + 1) && (k <= int'(len_q));
        for (int i = 0; i < MAX_LEN; i++) begin
          if (i < k) begin
            idx = int'(len_q) - k + i;
            if (idx < 0 || idx >= MAX_LEN)
              prefix_ok = 1'b0;
            else if (h[IW'(i)] != pat_q[IW'(idx)])
              prefix_ok = 1'b0;
          end
        end
        if (prefix_ok)
          next_state = LEN_W'(k);
      end
    end
  end

  // All state lives here; z is registered alongside the state it decodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q <= RST_PATTERN;
      len_q <= LEN_W'(RST_LEN);
      ovl_q <= RST_OVERLAP;
      state <= '0;
      z_q   <= 1'b0;
      hist  <= '0;
      cnt   <= '0;
    end else begin
      if (cfg_load) begin
        pat_q <= cfg_pattern;
        len_q <= len_clamped;
        ovl_q <= cfg_overlap;
        state <= '0;
        z_q   <= 1'b0;
        hist  <= '0;
      end else if (en) begin
        state <= next_state;
        z_q   <= (next_state == len_q);
        hist  <= h[MAX_LEN-2:0];
      end

      if (cnt_clr)
        cnt <= '0;
      else if (!cfg_load && en && next_state == len_q && cnt != {CNT_W{1'b1}})
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign z           = z_q;
  assign match_count = cnt;
  assign cur_len     = state;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed self-checking bench for seq_detect_prog; a second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       reset;
  logic       x;
  logic       en;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       cnt_clr;
  logic       z;
  logic [7:0] match_count;
  logic [3:0] cur_len;
  logic       z2;
  logic [1:0] match_count2;
  logic [3:0] cur_len2;

  int n_checks = 0;
  int n_pass   = 0;

  seq_detect_prog dut (
    .clk(clk), .reset(reset), .x(x), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z), .match_count(match_count), .cur_len(cur_len)
  );

  seq_detect_prog #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .x(x), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z2), .match_count(match_count2), .cur_len(cur_len2)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    x  = b;
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_load    = 1'b1;
    cnt_clr     = 1'b1;
    tick();
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (z !== 1'b0) $display("[TB] FAIL reset_z got %b want 0", z);
    else n_pass++;
    n_checks++;
    if (match_count !== 8'd0) $display("[TB] FAIL reset_count got %0d want 0", match_count);
    else n_pass++;
    n_checks++;
    if (cur_len !== 4'd0) $display("[TB] FAIL reset_cur_len got %0d want 0", cur_len);
    else n_pass++;
  endtask

  task automatic test_default_overlap();
    logic [6:0] stream;
    logic [6:0] exp_z;
    stream = 7'b1011011;
    exp_z  = 7'b0001001;
    for (int i = 0; i < 7; i++) begin
      send_bit(stream[6-i]);
      n_checks++;
      if (z !== exp_z[6-i]) $display("[TB] FAIL default_z bit%0d got %b want %b", i, z, exp_z[6-i]);
      else n_pass++;
    end
    n_checks++;
    if (match_count !== 8'd2) $display("[TB] FAIL default_count got %0d want 2", match_count);
    else n_pass++;
  endtask

  task automatic test_non_overlap();
    logic [6:0] stream;
    logic [6:0] exp_z;
    stream = 7'b1011011;
    exp_z  = 7'b0001000;
    load_cfg(8'h0B, 4'd4, 1'b0);
    n_checks++;
    if (match_count !== 8'd0) $display("[TB] FAIL nonovl_clr got %0d want 0", match_count);
    else n_pass++;
    for (int i = 0; i < 7; i++) begin
      send_bit(stream[6-i]);
      n_checks++;
      if (z !== exp_z[6-i]) $display("[TB] FAIL nonovl_z bit%0d got %b want %b", i, z, exp_z[6-i]);
      else n_pass++;
    end
    n_checks++;
    if (match_count !== 8'd1) $display("[TB] FAIL nonovl_count got %0d want 1", match_count);
    else n_pass++;
  endtask

  task automatic test_ones(input logic ovl, input logic [4:0] exp_z, input logic [7:0] exp_cnt);
    load_cfg(8'h07, 4'd3, ovl);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
      n_checks++;
      if (z !== exp_z[4-i]) $display("[TB] FAIL ones_ovl%b_z bit%0d got %b want %b", ovl, i, z, exp_z[4-i]);
      else n_pass++;
    end
    n_checks++;
    if (match_count !== exp_cnt) $display("[TB] FAIL ones_ovl%b_count got %0d want %0d", ovl, match_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_en_gating();
    logic [7:0] stream;
    stream = 8'hA5;
    load_cfg(8'hA5, 4'd8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send_bit(stream[7-i]);
      n_checks++;
      if (cur_len !== 4'(i + 1)) $display("[TB] FAIL engate_state bit%0d got %0d want %0d", i, cur_len, i + 1);
      else n_pass++;
      x  = ~stream[7-i];
      en = 1'b0;
      tick();
      n_checks++;
      if (cur_len !== 4'(i + 1)) $display("[TB] FAIL engate_hold bit%0d got %0d want %0d", i, cur_len, i + 1);
      else n_pass++;
    end
    n_checks++;
    if (z !== 1'b1) $display("[TB] FAIL engate_z got %b want 1", z);
    else n_pass++;
    n_checks++;
    if (match_count !== 8'd1) $display("[TB] FAIL engate_count got %0d want 1", match_count);
    else n_pass++;
  endtask

  task automatic test_reload_and_async_reset();
    load_cfg(8'h0B, 4'd4, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    n_checks++;
    if (cur_len !== 4'd3) $display("[TB] FAIL reload_pre got %0d want 3", cur_len);
    else n_pass++;
    cfg_load = 1'b1;
    x        = 1'b1;
    en       = 1'b1;
    tick();
    cfg_load = 1'b0;
    en       = 1'b0;
    n_checks++;
    if (cur_len !== 4'd0 || z !== 1'b0) $display("[TB] FAIL reload_restart got len=%0d z=%b want len=0 z=0", cur_len, z);
    else n_pass++;
    n_checks++;
    if (match_count !== 8'd0) $display("[TB] FAIL reload_count got %0d want 0", match_count);
    else n_pass++;
    send_bit(1'b1);
    n_checks++;
    if (cur_len !== 4'd1 || z !== 1'b0) $display("[TB] FAIL reload_next got len=%0d z=%b want len=1 z=0", cur_len, z);
    else n_pass++;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    n_checks++;
    if (z !== 1'b1 || match_count !== 8'd1) $display("[TB] FAIL premreset got z=%b cnt=%0d want z=1 cnt=1", z, match_count);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (z !== 1'b0 || match_count !== 8'd0 || cur_len !== 4'd0)
      $display("[TB] FAIL async_reset got z=%b cnt=%0d len=%0d want 0/0/0", z, match_count, cur_len);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_saturation_and_lengths();
    load_cfg(8'h01, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
      n_checks++;
      if (z !== 1'b1) $display("[TB] FAIL len0_z bit%0d got %b want 1", i, z);
      else n_pass++;
    end
    n_checks++;
    if (match_count2 !== 2'd3) $display("[TB] FAIL sat_count got %0d want 3", match_count2);
    else n_pass++;
    n_checks++;
    if (match_count !== 8'd5) $display("[TB] FAIL len0_count got %0d want 5", match_count);
    else n_pass++;
    send_bit(1'b0);
    n_checks++;
    if (z !== 1'b0) $display("[TB] FAIL len0_zero got %b want 0", z);
    else n_pass++;
    cnt_clr = 1'b1;
    send_bit(1'b1);
    cnt_clr = 1'b0;
    n_checks++;
    if (match_count !== 8'd0 || match_count2 !== 2'd0 || z !== 1'b1)
      $display("[TB] FAIL clr_on_match got cnt=%0d cnt2=%0d z=%b want 0/0/1", match_count, match_count2, z);
    else n_pass++;
    load_cfg(8'hFF, 4'd15, 1'b1);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    n_checks++;
    if (z !== 1'b0 || cur_len !== 4'd7) $display("[TB] FAIL len15_pre got z=%b len=%0d want z=0 len=7", z, cur_len);
    else n_pass++;
    send_bit(1'b1);
    n_checks++;
    if (z !== 1'b1 || cur_len !== 4'd8) $display("[TB] FAIL len15_match got z=%b len=%0d want z=1 len=8", z, cur_len);
    else n_pass++;
  endtask

  initial begin
    reset       = 1'b1;
    x           = 1'b0;
    en          = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = 8'h00;
    cfg_len     = 4'd0;
    cfg_overlap = 1'b0;
    cnt_clr     = 1'b0;
    test_reset();
    test_default_overlap();
    test_non_overlap();
    test_ones(1'b1, 5'b00111, 8'd3);
    test_ones(1'b0, 5'b00100, 8'd1);
    test_en_gating();
    test_reload_and_async_reset();
    test_saturation_and_lengths();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
